// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, frame defaults and the
// parity helper, kept here so the receiver can use the same encoding.
package uart_pkg;

  localparam int UART_DATA_BITS_DEFAULT = 8;
  localparam int UART_STOP_BITS_DEFAULT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // XOR of the low data_bits bits of data, inverted for odd parity.
  function automatic logic uart_parity(input logic [7:0] data, input int data_bits,
                                       input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < data_bits) begin
        p = p ^ data[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_framer_hold_buffer.sv
// One-entry holding register in front of the transmit shifter. Lets one
// byte wait while the previous frame is still going out on the line.
module tx_hold_buffer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_pop,
  output logic       o_hold_valid,
  output logic [7:0] o_hold_data
);

  logic       r_hold_valid;
  logic [7:0] r_hold_data;
  logic       w_push;

  // Accept only into an empty slot, so data changes without a handshake are ignored.
  assign w_push = i_valid && !r_hold_valid;

  // Capture on handshake; release when the framer loads the byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= 8'h00;
    end else if (w_push) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= i_data;
    end else if (i_pop) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign o_ready      = !r_hold_valid;
  assign o_hold_valid = r_hold_valid;
  assign o_hold_data  = r_hold_data;

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS data bits LSB first, optional
// parity, STOP_BITS stop bits. Every bit boundary falls on a baud_clk strobe
// supplied by an external baud generator.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = UART_STOP_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clk,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic        r_stop_cnt;
  logic        r_parity;
  logic        r_serial;

  logic        w_hold_valid;
  logic [7:0]  w_hold_data;
  logic        w_frame_end;
  logic        w_pop;

  // Last baud period of the final stop bit: the point where a queued byte
  // can follow without an idle gap.
  assign w_frame_end = (r_state == ST_STOP) && (r_stop_cnt == LAST_STOP);

  // A queued byte is taken only on a strobe, from IDLE or at frame end.
  assign w_pop = baud_clk && w_hold_valid && ((r_state == ST_IDLE) || w_frame_end);

  tx_hold_buffer u_hold (
    .clk          (clk),
    .reset        (reset),
    .i_data       (tx_data),
    .i_valid      (tx_valid),
    .o_ready      (tx_ready),
    .i_pop        (w_pop),
    .o_hold_valid (w_hold_valid),
    .o_hold_data  (w_hold_data)
  );

  // Frame sequencer: advances only on baud strobes; the line is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_serial   <= 1'b1;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
    end else if (baud_clk) begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift  <= w_hold_data;
            r_parity <= uart_parity(w_hold_data, DATA_BITS, PARITY_ODD != 0);
            r_serial <= 1'b0;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          r_serial  <= r_shift[0];
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_cnt <= 3'd0;
          r_state   <= ST_DATA;
        end
        ST_DATA: begin
          if (r_bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              r_serial <= r_parity;
              r_state  <= ST_PARITY;
            end else begin
              r_serial   <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= ST_STOP;
            end
          end else begin
            r_serial  <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          r_serial   <= 1'b1;
          r_stop_cnt <= 1'b0;
          r_state    <= ST_STOP;
        end
        ST_STOP: begin
          if (w_frame_end) begin
            if (w_hold_valid) begin
              r_shift  <= w_hold_data;
              r_parity <= uart_parity(w_hold_data, DATA_BITS, PARITY_ODD != 0);
              r_serial <= 1'b0;
              r_state  <= ST_START;
            end else begin
              r_serial <= 1'b1;
              r_state  <= ST_IDLE;
            end
          end else begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end
        default: begin
          r_serial <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign serial_out = r_serial;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter PARITY_EN, default 0, 1 = append a parity bit after the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
REQ-004 SHALL have parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-007 SHALL have port baud_clk, input, 1, single-cycle strobe, one pulse per bit period, from the upstream baud generator.
REQ-008 SHALL have port tx_data, input, 8, byte to send; only bits [DATA_BITS-1:0] are transmitted.
REQ-009 SHALL have port tx_valid, input, 1, tx_data is valid.
REQ-010 SHALL have port tx_ready, output, 1, the block can accept a byte this cycle.
REQ-011 SHALL have port serial_out, output, 1, registered UART line, idle high.
REQ-012 SHALL have port busy, output, 1, a frame is on the line (state != IDLE).

Function
REQ-013 SHALL accept a byte on any clk edge where tx_valid && tx_ready, capturing it into a one-entry holding register (hold_valid <= 1).
REQ-014 SHALL drive tx_ready = !hold_valid combinationally, so one byte can be queued while another is shifting.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, and SHALL change state only on cycles where baud_clk=1.
REQ-016 IDLE: on a baud_clk with hold_valid=1, SHALL load the shift register from the holding register, clear hold_valid, drive serial_out <= 0, and go to START.
REQ-017 START -> DATA on the next baud_clk, driving serial_out <= bit 0 (LSB first); the bit counter resets to 0.
REQ-018 DATA: each baud_clk SHALL output the next bit. After DATA_BITS bits have been held for one period each, the next baud_clk SHALL go to PARITY (PARITY_EN=1) or STOP, driving serial_out <= parity or 1 respectively.
REQ-019 The parity bit SHALL be the XOR of the DATA_BITS transmitted bits, inverted when PARITY_ODD=1.
REQ-020 STOP: SHALL hold serial_out=1 for STOP_BITS bit periods. On the baud_clk ending the last stop period, the block SHALL:
- with hold_valid=1, behave as REQ-016 (back-to-back frame, no idle gap);
- otherwise go to IDLE with serial_out=1.
REQ-021 Every bit, including start, parity and stop bits, SHALL last exactly one baud_clk-to-baud_clk interval.
REQ-022 A byte accepted on the same edge as a baud_clk in IDLE SHALL NOT start on that edge; it SHALL start on the first baud_clk strictly after acceptance.
REQ-023 tx_data changes while not accepted SHALL have no effect; the holding register SHALL be written only on a handshake.
REQ-024 busy SHALL be 1 exactly while state != IDLE.

Reset
REQ-025 On reset=0, the block SHALL immediately, without waiting for clk:
- set state IDLE, serial_out=1, busy=0, hold_valid=0 (tx_ready=1);
- clear the bit counter, stop counter and shift register.
REQ-026 Reset asserted mid-frame SHALL abort the frame, return the line high, and discard any queued byte.

Structure
REQ-027 SHALL place the state enumeration and the default values of DATA_BITS and STOP_BITS in shared package uart_pkg, for reuse by the receiver.
REQ-028 SHALL instantiate exactly one sub-module, tx_hold_buffer, containing the holding register and tx_ready logic. The baud_generator SHALL be instantiated by the parent, not inside this block.

Verification (baud_clk pulsed every 8 clk)
REQ-029 Default 8N1, send 0xA5 -> serial_out per bit period = 0,1,0,1,0,0,1,0,1,1, then idle high; busy high for exactly 10 periods.
REQ-030 PARITY_EN=1, PARITY_ODD=0, send 0xA5 -> parity bit 0. Repeat with PARITY_ODD=1 -> parity bit 1. Frame length 11 periods.
REQ-031 Send 0x01 then 0xFF with tx_valid held high -> second byte accepted during the first frame, its start bit immediately follows the stop bit (20 contiguous periods), tx_ready low while queued.
REQ-032 STOP_BITS=2, send 0x00 -> line 0 for 9 periods, then 1 for 2 periods before a queued byte's start bit.
REQ-033 Assert reset=0 during data bit 3 of 0x55 with a byte queued -> serial_out=1, busy=0, tx_ready=1 asynchronously; no further frame after release until a new handshake.
REQ-034 Handshake on the same edge as a baud_clk in IDLE -> start bit appears at the following baud_clk, not the current one.
